// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter
// Shares the single register-file write port between the in-order writeback
// stage (port 0) and the long-latency unit (port 1). Port 0 has fixed priority.
// With RF_WPORT_AGING_EN defined, a wait counter force-grants port 1 after it
// has been refused MAX_WAIT cycles. Without it, port 1 may starve.
// Accepted results are registered once, then presented on ws_to_rf_bus and the
// trace debug interface one cycle after the handshake.
module rf_wport_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_valid,
    output logic        p0_ready,
    input  logic        p0_we,
    input  logic [4:0]  p0_dest,
    input  logic [31:0] p0_wdata,
    input  logic [31:0] p0_pc,
    input  logic        p1_valid,
    output logic        p1_ready,
    input  logic        p1_we,
    input  logic [4:0]  p1_dest,
    input  logic [31:0] p1_wdata,
    input  logic [31:0] p1_pc,
    output logic [37:0] ws_to_rf_bus,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
);

    logic        force_p1;
    logic        take0;
    logic        take1;
    logic        rf_we;
    logic        out_v_reg;
    logic        out_we_reg;
    logic [4:0]  out_dest_reg;
    logic [31:0] out_data_reg;
    logic [31:0] out_pc_reg;

    // The counter must be able to hold MAX_WAIT; an out-of-range pair leaves
    // this empty marker block in the elaborated hierarchy.
    if ((MAX_WAIT < 1) || (MAX_WAIT >= (1 << CNT_W))) begin : g_param_out_of_range
    end

`ifdef RF_WPORT_AGING_EN
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] wait_cnt_reg;
    logic [CNT_W-1:0] wait_cnt_next;

    // The count is treated as zero while reset is held, so readys during
    // reset follow plain port-0 priority.
    assign force_p1 = !reset && (wait_cnt_reg == MAX_CNT) && p1_valid;

    // Count refused cycles of a waiting port 1, saturating; clear otherwise.
    always_comb begin
        wait_cnt_next = '0;
        if (p1_valid && !p1_ready) begin
            wait_cnt_next = (wait_cnt_reg == MAX_CNT) ? MAX_CNT : wait_cnt_reg + 1'b1;
        end
    end

    // Wait counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_reg <= '0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
        end
    end
`else
    assign force_p1 = 1'b0;
`endif

    // Readys depend only on valids and the wait count, never on each other's
    // handshake, so there is no valid-to-valid combinational path.
    assign p0_ready = !force_p1;
    assign p1_ready = force_p1 || !p0_valid;

    assign take0 = p0_valid && p0_ready;
    assign take1 = p1_valid && p1_ready && !take0;

    // Capture the granted result; payload is held when nothing transfers.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_v_reg    <= 1'b0;
            out_we_reg   <= 1'b0;
            out_dest_reg <= '0;
            out_data_reg <= '0;
            out_pc_reg   <= '0;
        end else if (take0) begin
            out_v_reg    <= 1'b1;
            out_we_reg   <= p0_we && (p0_dest != 5'd0);
            out_dest_reg <= p0_dest;
            out_data_reg <= p0_wdata;
            out_pc_reg   <= p0_pc;
        end else if (take1) begin
            out_v_reg    <= 1'b1;
            out_we_reg   <= p1_we && (p1_dest != 5'd0);
            out_dest_reg <= p1_dest;
            out_data_reg <= p1_wdata;
            out_pc_reg   <= p1_pc;
        end else begin
            out_v_reg    <= 1'b0;
        end
    end

    // A write reaches the register file for exactly one cycle per accepted result.
    assign rf_we        = out_v_reg && out_we_reg;
    assign ws_to_rf_bus = {rf_we, out_dest_reg, out_data_reg};

    assign debug_wb_pc       = out_pc_reg;
    assign debug_wb_rf_wnum  = out_dest_reg;
    assign debug_wb_rf_wdata = out_data_reg;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dbg_wen
        assign debug_wb_rf_wen[gi] = rf_we;
    end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// tb_rf_wport_arbiter
// Randomized and directed stimulus against a behavioural model of the write
// port arbiter. Expected register-file writes are queued when a handshake is
// predicted; a separate monitor pops and compares them as they appear.
// Honors RF_WPORT_AGING_EN to select the expected grant policy.
module tb_rf_wport_arbiter;

    localparam int MAX_WAIT = 4;
`ifdef RF_WPORT_AGING_EN
    localparam bit AGING = 1'b1;
`else
    localparam bit AGING = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_valid, p0_ready, p0_we;
    logic [4:0]  p0_dest;
    logic [31:0] p0_wdata, p0_pc;
    logic        p1_valid, p1_ready, p1_we;
    logic [4:0]  p1_dest;
    logic [31:0] p1_wdata, p1_pc;
    logic [37:0] ws_to_rf_bus;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    rf_wport_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_dest(p0_dest),
        .p0_wdata(p0_wdata), .p0_pc(p0_pc),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_dest(p1_dest),
        .p1_wdata(p1_wdata), .p1_pc(p1_pc),
        .ws_to_rf_bus(ws_to_rf_bus), .debug_wb_pc(debug_wb_pc),
        .debug_wb_rf_wen(debug_wb_rf_wen), .debug_wb_rf_wnum(debug_wb_rf_wnum),
        .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [4:0]  dest;
        logic [31:0] data;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_pass  = 0;
    int          n_total = 0;
    int          cyc     = 0;
    bit          mon_en  = 1'b0;
    int          m_wait  = 0;     // consecutive cycles port 1 has been refused
    int          prob0   = 0;
    int          prob1   = 0;
    bit          force_r0 = 1'b0;
    logic [31:0] pc_seq  = 32'h1000_0000;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Sources present a new result only when idle, then hold it until accepted.
    task automatic refill();
        if (!p0_valid && ($urandom_range(99) < 32'(prob0))) begin
            p0_valid = 1'b1;
            p0_we    = ($urandom_range(9) != 0);
            p0_dest  = 5'($urandom_range(31));
            p0_wdata = $urandom;
            p0_pc    = pc_seq;
            pc_seq   = pc_seq + 32'd4;
            if (force_r0) begin
                p0_we    = 1'b1;
                p0_dest  = 5'd0;
                p0_wdata = 32'hFFFF_FFFF;
            end
        end
        if (!p1_valid && ($urandom_range(99) < 32'(prob1))) begin
            p1_valid = 1'b1;
            p1_we    = ($urandom_range(9) != 0);
            p1_dest  = 5'($urandom_range(31));
            p1_wdata = $urandom;
            p1_pc    = pc_seq;
            pc_seq   = pc_seq + 32'd4;
        end
    endtask

    // One clock cycle: predict readys, check them, predict the transfer.
    task automatic step();
        bit ef, er0, er1, t0, t1;
        int w;
        @(negedge clk);
        w   = reset ? 0 : m_wait;
        ef  = AGING && (w >= MAX_WAIT) && p1_valid;
        er0 = !ef;
        er1 = ef || !p0_valid;
        check("p0_ready", 64'(p0_ready), 64'(er0));
        check("p1_ready", 64'(p1_ready), 64'(er1));
        t0 = 1'b0;
        t1 = 1'b0;
        if (reset) begin
            m_wait = 0;
        end else begin
            t0 = p0_valid && er0;
            t1 = p1_valid && er1 && !t0;
            if (t0 && p0_we && (p0_dest != 5'd0)) sb_q.push_back('{cyc + 1, p0_dest, p0_wdata, p0_pc});
            if (t1 && p1_we && (p1_dest != 5'd0)) sb_q.push_back('{cyc + 1, p1_dest, p1_wdata, p1_pc});
            if (p1_valid && !er1) m_wait = (m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1;
            else m_wait = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (t0) p0_valid = 1'b0;
        if (t1) p1_valid = 1'b0;
        refill();
    endtask

    task automatic set_p0(logic [4:0] d, logic [31:0] v, logic [31:0] pc);
        p0_valid = 1'b1; p0_we = 1'b1; p0_dest = d; p0_wdata = v; p0_pc = pc;
    endtask

    task automatic set_p1(logic [4:0] d, logic [31:0] v, logic [31:0] pc);
        p1_valid = 1'b1; p1_we = 1'b1; p1_dest = d; p1_wdata = v; p1_pc = pc;
    endtask

    task automatic check_cleared(string tag);
        check({tag, "_bus"},   64'(ws_to_rf_bus),      64'd0);
        check({tag, "_pc"},    64'(debug_wb_pc),       64'd0);
        check({tag, "_wen"},   64'(debug_wb_rf_wen),   64'd0);
        check({tag, "_wnum"},  64'(debug_wb_rf_wnum),  64'd0);
        check({tag, "_wdata"}, 64'(debug_wb_rf_wdata), 64'd0);
    endtask

    // Monitor: whenever the model says a write is due, compare the rf bus and debug port.
    initial begin
        exp_t e;
        bit   exp_we;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                exp_we = (sb_q.size() > 0) && (sb_q[0].cyc == cyc);
                check("rf_we", 64'(ws_to_rf_bus[37]), 64'(exp_we));
                check("debug_wen", 64'(debug_wb_rf_wen), 64'({4{exp_we}}));
                if (exp_we) begin
                    e = sb_q.pop_front();
                    check("rf_waddr", 64'(ws_to_rf_bus[36:32]), 64'(e.dest));
                    check("rf_wdata", 64'(ws_to_rf_bus[31:0]), 64'(e.data));
                    check("debug_pc", 64'(debug_wb_pc), 64'(e.pc));
                    check("debug_wnum", 64'(debug_wb_rf_wnum), 64'(e.dest));
                    check("debug_wdata", 64'(debug_wb_rf_wdata), 64'(e.data));
                    $display("cycle %0d: rf write r%0d = %08h pc %08h", cyc, e.dest, e.data, e.pc);
                end
            end
        end
    end

    initial begin
        int guard;
        reset = 1'b1;
        p0_valid = 1'b0; p0_we = 1'b0; p0_dest = '0; p0_wdata = '0; p0_pc = '0;
        p1_valid = 1'b0; p1_we = 1'b0; p1_dest = '0; p1_wdata = '0; p1_pc = '0;
        step();
        step();
        check_cleared("reset");
        mon_en = 1'b1;
        reset  = 1'b0;

        // p0 alone: r1..r3, one write per cycle
        for (int i = 1; i <= 3; i++) begin
            set_p0(5'(i), 32'(i * 17), 32'h0000_0100 + 32'(i * 4));
            step();
        end
        step();
        step();

        // both valid: p0 first, p1 next cycle
        set_p0(5'd4, 32'h0000_000A, 32'h0000_0200);
        set_p1(5'd5, 32'h0000_000B, 32'h0000_0204);
        step();
        step();
        step();
        step();

        // r0 write: handshake completes, nothing reaches the register file
        set_p0(5'd0, 32'hFFFF_FFFF, 32'hBEEF_0000);
        step();
        check("r0_debug_pc", 64'(debug_wb_pc), 64'h0000_0000_BEEF_0000);
        check("r0_debug_wen", 64'(debug_wb_rf_wen), 64'd0);
        check("r0_bus_we", 64'(ws_to_rf_bus[37]), 64'd0);
        step();

        // continuous p0 with waiting p1: aging force-grant or starvation
        prob0 = 100;
        prob1 = 100;
        refill();
        repeat (14) step();

        // idle both, then rebuild a 3-cycle wait and reset in the middle of it
        prob0 = 0;
        prob1 = 0;
        guard = 0;
        while ((p0_valid || p1_valid) && guard < 20) begin
            step();
            guard++;
        end
        check("drain_timeout", 64'(p0_valid || p1_valid), 64'd0);
        prob0 = 100;
        prob1 = 100;
        refill();
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_cleared("midreset");
        repeat (10) step();

        // random traffic, including r0 writes for a stretch
        prob0 = 60;
        prob1 = 50;
        repeat (300) step();
        force_r0 = 1'b1;
        repeat (30) step();
        force_r0 = 1'b0;
        repeat (100) step();

        prob0 = 0;
        prob1 = 0;
        guard = 0;
        while ((p0_valid || p1_valid) && guard < 20) begin
            step();
            guard++;
        end
        step();
        step();
        check("final_drain", 64'(p0_valid || p1_valid), 64'd0);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
